// File: rtl/ctrl_pkg.sv
// Shared decode types for the RV32 ID stage: opcodes, ALU op codes, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: opcode / func7 constants, alu_op_e, wb_sel and jmp codes, ctrl_word_t.
package ctrl_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int ALU_OP_BITS = 5;

  typedef enum logic [ALU_OP_BITS-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SLL    = 5'd1,
    ALU_SLT    = 5'd2,
    ALU_SLTU   = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SRL    = 5'd5,
    ALU_SRA    = 5'd6,
    ALU_OR     = 5'd7,
    ALU_AND    = 5'd8,
    ALU_SUB    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_JAL  = 2'd1;
  localparam logic [1:0] JMP_JALR = 2'd2;

  typedef struct packed {
    alu_op_e    alu_op;
    logic [2:0] mask;
    logic [2:0] br_type;
    logic [1:0] jmp;
    logic       reg_wr;
    logic       sel_a;
    logic       sel_b;
    logic       rd_en;
    logic       wr_en;
    logic [1:0] wb_sel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
    logic       used_rs1;
    logic       used_rs2;
  } ctrl_word_t;

  // func3 -> ALU op for the func7=0 encodings shared by R-type and I-ALU.
  function automatic alu_op_e base_alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I(+M) instruction decoder: instruction word -> ctrl_word_t.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the enclosing stage decides when the word is captured.
// Ports: instr_i instruction word; ctrl_o decoded control word incl. illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr_i,
  output ctrl_word_t  ctrl_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_ADD;
    ctrl_o.rd     = instr_i[11:7];
    ctrl_o.rs1    = instr_i[19:15];
    ctrl_o.rs2    = instr_i[24:20];
    case (opc)
      OPC_R: begin
        ctrl_o.reg_wr   = 1'b1;
        ctrl_o.sel_a    = 1'b1;
        ctrl_o.used_rs1 = 1'b1;
        ctrl_o.used_rs2 = 1'b1;
        if (f7 == F7_BASE)                        ctrl_o.alu_op = base_alu_op(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)    ctrl_o.alu_op = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)    ctrl_o.alu_op = ALU_SRA;
        // M ops are laid out contiguously from ALU_MUL in func3 order.
        else if (EN_M && f7 == F7_MULDIV)         ctrl_o.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(f3));
        else                                      ctrl_o.illegal = 1'b1;
      end
      OPC_I: begin
        ctrl_o.reg_wr   = 1'b1;
        ctrl_o.sel_a    = 1'b1;
        ctrl_o.sel_b    = 1'b1;
        ctrl_o.used_rs1 = 1'b1;
        // Only the shift-immediates carry a func7 field; other func3 use imm[11:5].
        case (f3)
          3'b001: begin
            if (f7 == F7_BASE) ctrl_o.alu_op  = ALU_SLL;
            else               ctrl_o.illegal = 1'b1;
          end
          3'b101: begin
            if (f7 == F7_BASE)     ctrl_o.alu_op  = ALU_SRL;
            else if (f7 == F7_ALT) ctrl_o.alu_op  = ALU_SRA;
            else                   ctrl_o.illegal = 1'b1;
          end
          default: ctrl_o.alu_op = base_alu_op(f3);
        endcase
      end
      OPC_LOAD: begin
        ctrl_o.reg_wr   = 1'b1;
        ctrl_o.sel_a    = 1'b1;
        ctrl_o.sel_b    = 1'b1;
        ctrl_o.rd_en    = 1'b1;
        ctrl_o.wb_sel   = WB_MEM;
        ctrl_o.mask     = f3;
        ctrl_o.used_rs1 = 1'b1;
      end
      OPC_STORE: begin
        ctrl_o.sel_a    = 1'b1;
        ctrl_o.sel_b    = 1'b1;
        ctrl_o.rd_en    = 1'b1;
        ctrl_o.wr_en    = 1'b1;
        ctrl_o.mask     = f3;
        ctrl_o.used_rs1 = 1'b1;
        ctrl_o.used_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl_o.sel_b    = 1'b1;
        ctrl_o.br_type  = f3;
        ctrl_o.used_rs1 = 1'b1;
        ctrl_o.used_rs2 = 1'b1;
      end
      OPC_LUI: begin
        ctrl_o.reg_wr = 1'b1;
        ctrl_o.sel_a  = 1'b1;
        ctrl_o.sel_b  = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_o.reg_wr = 1'b1;
        ctrl_o.sel_b  = 1'b1;
      end
      OPC_JAL: begin
        ctrl_o.reg_wr = 1'b1;
        ctrl_o.sel_b  = 1'b1;
        ctrl_o.wb_sel = WB_PC4;
        ctrl_o.jmp    = JMP_JAL;
      end
      OPC_JALR: begin
        ctrl_o.reg_wr   = 1'b1;
        ctrl_o.sel_a    = 1'b1;
        ctrl_o.sel_b    = 1'b1;
        ctrl_o.wb_sel   = WB_PC4;
        ctrl_o.jmp      = JMP_JALR;
        ctrl_o.used_rs1 = 1'b1;
        if (f3 != 3'b000) ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    // An illegal word still flows to EX but must have no architectural side effects,
    // and must not stall the pipe on a register it never really reads.
    if (ctrl_o.illegal) begin
      ctrl_o.reg_wr   = 1'b0;
      ctrl_o.rd_en    = 1'b0;
      ctrl_o.wr_en    = 1'b0;
      ctrl_o.jmp      = JMP_NONE;
      ctrl_o.used_rs1 = 1'b0;
      ctrl_o.used_rs2 = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered ID/EX decode stage with load-use bubble insertion and flush.
// Latency: 1 cycle, throughput 1 instr/cycle (one bubble after a dependent load).
// Backpressure: holds the control word while out_valid && !out_ready; in_ready drops.
// Ports: fetch side in_valid/in_ready/instr/pc, flush; EX side out_valid/out_ready,
//        out_pc/out_instr and the decoded control fields (alu_op .. illegal).
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter bit EN_M        = 1'b0,
  parameter bit EN_LOAD_USE = 1'b1,
  parameter int ALU_OP_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic [31:0]         pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_instr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          mask,
  output logic [2:0]          br_type,
  output logic [1:0]          jmp,
  output logic                reg_wr,
  output logic                sel_A,
  output logic                sel_B,
  output logic                rd_en,
  output logic                wr_en,
  output logic [1:0]          wb_sel,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic                illegal
);

  ctrl_word_t dec_w;
  ctrl_word_t ctrl_q, ctrl_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic        v_q, v_d;
  logic        hz_v_q, hz_v_d;
  logic [4:0]  hz_rd_q, hz_rd_d;
  logic        bubble, in_fire, out_hs, is_load;

  ctrl_decode #(.EN_M(EN_M)) u_dec (
    .instr_i (instr),
    .ctrl_o  (dec_w)
  );

  // hz_v_q is only ever set for the single cycle right after the load left,
  // so each load can cost at most one bubble.
  assign bubble = EN_LOAD_USE && hz_v_q && v_q &&
                  ((ctrl_q.used_rs1 && ctrl_q.rs1 == hz_rd_q) ||
                   (ctrl_q.used_rs2 && ctrl_q.rs2 == hz_rd_q));

  assign out_valid = v_q && !bubble;
  assign in_ready  = !reset && !flush && (!v_q || (out_ready && !bubble));
  assign in_fire   = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  // Illegal words have rd_en cleared, so they never arm the interlock.
  assign is_load   = ctrl_q.rd_en && !ctrl_q.wr_en;

  always_comb begin
    v_d     = v_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    hz_v_d  = 1'b0;
    hz_rd_d = hz_rd_q;
    if (flush) begin
      // A handshake coincident with flush still completes on the EX side,
      // but the stage empties and no hazard is carried forward.
      v_d    = 1'b0;
      hz_v_d = 1'b0;
    end else begin
      if (EN_LOAD_USE && out_hs && is_load && ctrl_q.rd != 5'd0) begin
        hz_v_d  = 1'b1;
        hz_rd_d = ctrl_q.rd;
      end
      if (in_fire) begin
        v_d     = 1'b1;
        ctrl_d  = dec_w;
        pc_d    = pc;
        instr_d = instr;
      end else if (out_hs) begin
        v_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q     <= 1'b0;
      ctrl_q  <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      hz_v_q  <= 1'b0;
      hz_rd_q <= '0;
    end else begin
      v_q     <= v_d;
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      hz_v_q  <= hz_v_d;
      hz_rd_q <= hz_rd_d;
    end
  end

  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign alu_op    = ALU_OP_W'(ctrl_q.alu_op);
  assign mask      = ctrl_q.mask;
  assign br_type   = ctrl_q.br_type;
  assign jmp       = ctrl_q.jmp;
  assign reg_wr    = ctrl_q.reg_wr;
  assign sel_A     = ctrl_q.sel_a;
  assign sel_B     = ctrl_q.sel_b;
  assign rd_en     = ctrl_q.rd_en;
  assign wr_en     = ctrl_q.wr_en;
  assign wb_sel    = ctrl_q.wb_sel;
  assign rd        = ctrl_q.rd;
  assign rs1       = ctrl_q.rs1;
  assign rs2       = ctrl_q.rs2;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: dut_a (EN_M=1, EN_LOAD_USE=1), dut_b (EN_M=0, EN_LOAD_USE=0).
// Latency under test: 1 cycle, plus one bubble for a dependent load on dut_a.
// Backpressure under test: out_ready stalls, flush, bubble-driven in_ready drop.
module tb_ctrl_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  alu;
    logic        reg_wr, sel_a, sel_b, rd_en, wr_en;
    logic [1:0]  jmp, wb;
    logic [2:0]  mask, br;
    logic        ill;
    logic [4:0]  rd, rs1, rs2;
  } obs_t;

  typedef struct packed {
    obs_t o;
    bit   chk_alu;
  } exp_t;

  // {reg_wr, sel_A, sel_B, rd_en, wr_en}
  localparam logic [4:0] F_R   = 5'b11000;
  localparam logic [4:0] F_I   = 5'b11100;
  localparam logic [4:0] F_LD  = 5'b11110;
  localparam logic [4:0] F_ST  = 5'b01111;
  localparam logic [4:0] F_BR  = 5'b00100;
  localparam logic [4:0] F_AUI = 5'b10100;

  localparam logic [31:0] W_ADD3  = 32'h002081B3;
  localparam logic [31:0] W_LW5   = 32'h0000A283;
  localparam logic [31:0] W_LW2   = 32'h0000A103;
  localparam logic [31:0] W_LW0   = 32'h0000A003;
  localparam logic [31:0] W_ADD65 = 32'h00228333;
  localparam logic [31:0] W_ADD60 = 32'h00200333;
  localparam logic [31:0] W_ADDI  = 32'h00138313;
  localparam logic [31:0] W_SUB   = 32'h40208133;
  localparam logic [31:0] W_MUL   = 32'h022081B3;
  localparam logic [31:0] W_JALR  = 32'h000100E7;

  logic        clk, reset, in_valid, flush, out_ready;
  logic [31:0] instr, pc;

  logic        a_in_ready, a_out_valid, a_reg_wr, a_sel_A, a_sel_B, a_rd_en, a_wr_en, a_illegal;
  logic [31:0] a_out_pc, a_out_instr;
  logic [4:0]  a_alu_op, a_rd, a_rs1, a_rs2;
  logic [2:0]  a_mask, a_br_type;
  logic [1:0]  a_jmp, a_wb_sel;

  logic        b_in_ready, b_out_valid, b_reg_wr, b_sel_A, b_sel_B, b_rd_en, b_wr_en, b_illegal;
  logic [31:0] b_out_pc, b_out_instr;
  logic [4:0]  b_alu_op, b_rd, b_rs1, b_rs2;
  logic [2:0]  b_mask, b_br_type;
  logic [1:0]  b_jmp, b_wb_sel;

  int errors = 0;
  int checks = 0;

  logic [31:0] stim_q[$];
  exp_t        stim_e[$];
  exp_t        sb_q[$];
  int          hs_cyc[$];
  bit          ov_log[64];
  bit          ir_log[64];
  logic [4:0]  alu_log[64];

  ctrl_decode_stage #(.EN_M(1'b1), .EN_LOAD_USE(1'b1), .ALU_OP_W(5)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .out_instr(a_out_instr), .alu_op(a_alu_op), .mask(a_mask),
    .br_type(a_br_type), .jmp(a_jmp), .reg_wr(a_reg_wr), .sel_A(a_sel_A), .sel_B(a_sel_B),
    .rd_en(a_rd_en), .wr_en(a_wr_en), .wb_sel(a_wb_sel), .rd(a_rd), .rs1(a_rs1),
    .rs2(a_rs2), .illegal(a_illegal)
  );

  ctrl_decode_stage #(.EN_M(1'b0), .EN_LOAD_USE(1'b0), .ALU_OP_W(5)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .instr(instr), .pc(pc), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .out_instr(b_out_instr), .alu_op(b_alu_op), .mask(b_mask),
    .br_type(b_br_type), .jmp(b_jmp), .reg_wr(b_reg_wr), .sel_A(b_sel_A), .sel_B(b_sel_B),
    .rd_en(b_rd_en), .wr_en(b_wr_en), .wb_sel(b_wb_sel), .rd(b_rd), .rs1(b_rs1),
    .rs2(b_rs2), .illegal(b_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] w, input logic [4:0] alu, input bit chk,
                              input logic [4:0] flg, input logic [1:0] jmp_v,
                              input logic [1:0] wb_v, input logic [2:0] msk,
                              input logic [2:0] br_v);
    exp_t e;
    e.chk_alu = chk;
    e.o.pc    = 32'h0;
    e.o.instr = w;
    e.o.alu   = alu;
    {e.o.reg_wr, e.o.sel_a, e.o.sel_b, e.o.rd_en, e.o.wr_en} = flg;
    e.o.jmp   = jmp_v;
    e.o.wb    = wb_v;
    e.o.mask  = msk;
    e.o.br    = br_v;
    e.o.ill   = 1'b0;
    e.o.rd    = w[11:7];
    e.o.rs1   = w[19:15];
    e.o.rs2   = w[24:20];
    return e;
  endfunction

  function automatic obs_t get_obs(input bit use_b);
    obs_t o;
    if (use_b) o = {b_out_pc, b_out_instr, b_alu_op, b_reg_wr, b_sel_A, b_sel_B, b_rd_en,
                    b_wr_en, b_jmp, b_wb_sel, b_mask, b_br_type, b_illegal, b_rd, b_rs1, b_rs2};
    else       o = {a_out_pc, a_out_instr, a_alu_op, a_reg_wr, a_sel_A, a_sel_B, a_rd_en,
                    a_wr_en, a_jmp, a_wb_sel, a_mask, a_br_type, a_illegal, a_rd, a_rs1, a_rs2};
    return o;
  endfunction

  task automatic push(input logic [31:0] w, input exp_t e);
    stim_q.push_back(w);
    stim_e.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives stim_q through one DUT; expectations enter the scoreboard on input
  // acceptance and are matched against every output handshake.
  task automatic run_stream(input bit use_b, input int stall_from, input int stall_len);
    int   idx = 0;
    int   n = stim_q.size();
    int   c = 0;
    bit   done = 0;
    bit   ov, ir;
    exp_t e;
    obs_t o;
    sb_q.delete();
    hs_cyc.delete();
    while (!done) begin
      in_valid  = (idx < n);
      instr     = (idx < n) ? stim_q[idx] : 32'h0;
      pc        = 32'h1000 + 32'(4 * idx);
      out_ready = !(c >= stall_from && c < stall_from + stall_len);
      @(negedge clk);
      ov = use_b ? b_out_valid : a_out_valid;
      ir = use_b ? b_in_ready  : a_in_ready;
      if (c < 64) begin
        ov_log[c]  = ov;
        ir_log[c]  = ir;
        alu_log[c] = use_b ? b_alu_op : a_alu_op;
      end
      if (in_valid && ir) begin
        e = stim_e[idx];
        e.o.pc = pc;
        sb_q.push_back(e);
        idx++;
      end
      if (ov && out_ready) begin
        o = get_obs(use_b);
        hs_cyc.push_back(c);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: unexpected output word %h at cycle %0d, none outstanding", o, c);
        end else begin
          e = sb_q.pop_front();
          if (!e.chk_alu) o.alu = e.o.alu;
          if (o !== e.o) begin
            errors++;
            $display("FAIL sb_word: got %h expected %h (instr %h)", o, e.o, e.o.instr);
          end
        end
      end
      @(posedge clk); #1;
      c++;
      if (idx == n && sb_q.size() == 0) done = 1;
      else if (c >= 200) begin
        checks++; errors++;
        $display("FAIL stream_timeout: %0d words outstanding, required 0", sb_q.size() + n - idx);
        done = 1;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    stim_q.delete();
    stim_e.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; instr = W_ADD3; pc = 32'h100; out_ready = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_in_ready, a_out_valid, b_in_ready, b_out_valid} !== 4'b0) begin
        errors++;
        $display("FAIL reset_hs: in_ready/out_valid a,b = %b required 0000",
                 {a_in_ready, a_out_valid, b_in_ready, b_out_valid});
      end
    end
    checks++;
    if ({a_alu_op, a_reg_wr, a_jmp, a_illegal, a_rd, a_out_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outs: alu=%0d reg_wr=%b jmp=%0d ill=%b rd=%0d pc=%h required all 0",
               a_alu_op, a_reg_wr, a_jmp, a_illegal, a_rd, a_out_pc);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL release_ready: in_ready=%b required 1", a_in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_alu_op, a_reg_wr, a_sel_A, a_sel_B, a_rd} !== {1'b1, 5'd0, 3'b110, 5'd3}) begin
      errors++;
      $display("FAIL first_add: v=%b alu=%0d rw=%b A=%b B=%b rd=%0d required v=1 alu=0 rw=1 A=1 B=0 rd=3",
               a_out_valid, a_alu_op, a_reg_wr, a_sel_A, a_sel_B, a_rd);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(32'h12345237, mk(32'h12345237, 5'd0, 0, F_I,   2'd0, 2'd0, 3'd0, 3'd0)); // lui
    push(32'h00001297, mk(32'h00001297, 5'd0, 0, F_AUI, 2'd0, 2'd0, 3'd0, 3'd0)); // auipc
    push(32'h008000EF, mk(32'h008000EF, 5'd0, 0, F_AUI, 2'd1, 2'd2, 3'd0, 3'd0)); // jal
    push(W_JALR,       mk(W_JALR,       5'd0, 0, F_I,   2'd2, 2'd2, 3'd0, 3'd0)); // jalr
    push(32'h0020A223, mk(32'h0020A223, 5'd0, 0, F_ST,  2'd0, 2'd0, 3'd2, 3'd0)); // sw
    push(32'h00208463, mk(32'h00208463, 5'd0, 0, F_BR,  2'd0, 2'd0, 3'd0, 3'd0)); // beq
    push(32'h00209463, mk(32'h00209463, 5'd0, 0, F_BR,  2'd0, 2'd0, 3'd0, 3'd1)); // bne
    push(32'h4030D393, mk(32'h4030D393, 5'd6, 1, F_I,   2'd0, 2'd0, 3'd0, 3'd0)); // srai
    push(32'h0020B433, mk(32'h0020B433, 5'd3, 1, F_R,   2'd0, 2'd0, 3'd0, 3'd0)); // sltu
    push(32'h0020E4B3, mk(32'h0020E4B3, 5'd7, 1, F_R,   2'd0, 2'd0, 3'd0, 3'd0)); // or
    push(32'h0220F533, mk(32'h0220F533, 5'd17, 1, F_R,  2'd0, 2'd0, 3'd0, 3'd0)); // remu
    push(32'h0020D5B3, mk(32'h0020D5B3, 5'd5, 1, F_R,   2'd0, 2'd0, 3'd0, 3'd0)); // srl
    push(32'h0050C613, mk(32'h0050C613, 5'd4, 1, F_I,   2'd0, 2'd0, 3'd0, 3'd0)); // xori
    push(W_LW5,        mk(W_LW5,        5'd0, 0, F_LD,  2'd0, 2'd1, 3'd2, 3'd0)); // lw
    run_stream(0, 99, 0);
    begin
      bit ok = (hs_cyc.size() == 14) && (hs_cyc[0] == 1);
      for (int i = 1; i < hs_cyc.size(); i++) if (hs_cyc[i] - hs_cyc[i-1] != 1) ok = 0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL b2b_rate: %0d handshakes, not one per cycle from cycle 1; required 14 back to back",
                 hs_cyc.size());
      end
    end
  endtask

  task automatic test_load_use();
    for (int d = 0; d < 2; d++) begin
      do_reset();
      push(W_LW5,   mk(W_LW5,   5'd0, 0, F_LD, 2'd0, 2'd1, 3'd2, 3'd0));
      push(W_ADD65, mk(W_ADD65, 5'd0, 1, F_R,  2'd0, 2'd0, 3'd0, 3'd0));
      run_stream(d == 1, 99, 0);
      checks++;
      if (hs_cyc.size() != 2) begin
        errors++; $display("FAIL lu_count: dut%0d %0d handshakes required 2", d, hs_cyc.size());
      end else if (hs_cyc[1] - hs_cyc[0] != (d == 0 ? 2 : 1)) begin
        errors++;
        $display("FAIL lu_gap: dut%0d spacing %0d required %0d", d, hs_cyc[1] - hs_cyc[0], d == 0 ? 2 : 1);
      end else if (d == 0 && (ov_log[hs_cyc[0]+1] || ir_log[hs_cyc[0]+1])) begin
        errors++;
        $display("FAIL lu_bubble: out_valid=%b in_ready=%b in bubble cycle required 0 0",
                 ov_log[hs_cyc[0]+1], ir_log[hs_cyc[0]+1]);
      end
    end
  endtask

  task automatic test_no_bubble();
    logic [31:0] ld_w [2];
    logic [31:0] use_w[2];
    ld_w[0] = W_LW0; use_w[0] = W_ADD60;
    ld_w[1] = W_LW5; use_w[1] = W_ADDI;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      push(ld_w[k], mk(ld_w[k], 5'd0, 0, F_LD, 2'd0, 2'd1, 3'd2, 3'd0));
      push(use_w[k], mk(use_w[k], 5'd0, 1, (k == 0) ? F_R : F_I, 2'd0, 2'd0, 3'd0, 3'd0));
      run_stream(0, 99, 0);
      checks++;
      if (hs_cyc.size() != 2 || hs_cyc[1] - hs_cyc[0] != 1) begin
        errors++;
        $display("FAIL no_bubble_%0d: %0d handshakes spacing %0d required 2 spaced 1",
                 k, hs_cyc.size(), (hs_cyc.size() == 2) ? hs_cyc[1] - hs_cyc[0] : -1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(W_SUB,  mk(W_SUB,  5'd9, 1, F_R, 2'd0, 2'd0, 3'd0, 3'd0));
    push(W_ADD3, mk(W_ADD3, 5'd0, 1, F_R, 2'd0, 2'd0, 3'd0, 3'd0));
    run_stream(0, 1, 4);
    for (int c = 1; c < 5; c++) begin
      checks++;
      if (!(ov_log[c] === 1'b1 && ir_log[c] === 1'b0 && alu_log[c] === 5'd9)) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b alu=%0d required 1 0 9",
                 c, ov_log[c], ir_log[c], alu_log[c]);
      end
    end
    checks++;
    if (hs_cyc.size() != 2 || hs_cyc[0] != 5 || hs_cyc[1] != 6) begin
      errors++;
      $display("FAIL hold_release: %0d handshakes first at %0d required 2 at cycles 5,6",
               hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] : -1);
    end
  endtask

  task automatic test_m_ext();
    do_reset();
    in_valid = 1'b1; instr = W_MUL; pc = 32'h300;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_alu_op, a_illegal, a_reg_wr} !== {1'b1, 5'd10, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mul_m1: v=%b alu=%0d ill=%b rw=%b required 1 10 0 1",
               a_out_valid, a_alu_op, a_illegal, a_reg_wr);
    end
    checks++;
    if ({b_out_valid, b_illegal, b_reg_wr, b_rd_en, b_wr_en, b_jmp} !== {1'b1, 1'b1, 3'b000, 2'd0}) begin
      errors++;
      $display("FAIL mul_m0: v=%b ill=%b rw=%b rd_en=%b wr_en=%b jmp=%0d required 1 1 0 0 0 0",
               b_out_valid, b_illegal, b_reg_wr, b_rd_en, b_wr_en, b_jmp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [31:0] words[4];
    words[0] = 32'h00000000;  // unknown opcode
    words[1] = 32'h000110E7;  // jalr func3=001
    words[2] = 32'h40209093;  // slli with func7 0100000
    words[3] = 32'h4020C1B3;  // xor with func7 0100000
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; instr = words[i]; pc = 32'h400 + 32'(4 * i);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({a_out_valid, a_illegal, a_reg_wr, a_rd_en, a_wr_en, a_jmp} !== {1'b1, 1'b1, 3'b000, 2'd0}) begin
        errors++;
        $display("FAIL illegal_%0d: v=%b ill=%b rw=%b rd_en=%b wr_en=%b jmp=%0d required 1 1 0 0 0 0",
                 i, a_out_valid, a_illegal, a_reg_wr, a_rd_en, a_wr_en, a_jmp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jalr_flush();
    do_reset();
    in_valid = 1'b1; instr = W_LW2; pc = 32'h200;
    @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fl_c0: in_ready=%b required 1", a_in_ready); end
    @(posedge clk); #1 instr = W_JALR; pc = 32'h204;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b11 || a_out_instr !== W_LW2) begin
      errors++;
      $display("FAIL fl_c1: v=%b rdy=%b instr=%h required 1 1 %h", a_out_valid, a_in_ready, a_out_instr, W_LW2);
    end
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready, a_jmp, a_wb_sel} !== {2'b00, 2'd2, 2'd2} || a_out_instr !== W_JALR) begin
      errors++;
      $display("FAIL fl_bubble: v=%b rdy=%b jmp=%0d wb=%0d instr=%h required 0 0 2 2 %h",
               a_out_valid, a_in_ready, a_jmp, a_wb_sel, a_out_instr, W_JALR);
    end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b1; instr = W_ADD65; pc = 32'h208;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++; $display("FAIL fl_after: v=%b rdy=%b required 0 1", a_out_valid, a_in_ready);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_instr !== W_ADD65) begin
      errors++;
      $display("FAIL fl_next: v=%b instr=%h required 1 %h", a_out_valid, a_out_instr, W_ADD65);
    end
    @(posedge clk); #1 flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      errors++; $display("FAIL fl_coinc: v=%b rdy=%b required 1 0", a_out_valid, a_in_ready);
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      errors++; $display("FAIL fl_empty: v=%b rdy=%b required 0 1", a_out_valid, a_in_ready);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_no_bubble();
    test_backpressure();
    test_m_ext();
    test_illegal();
    test_jalr_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
Name: ctrl_decode_stage

Overview:
- Registered, parametrised decode/control stage for the RV32 core. Generation 2 of the combinational controller.
- Decodes one instruction per cycle into a control word held in an ID/EX output register, with a valid/ready handshake on both sides.
- Adds the following:
  - AUIPC, JALR and optional M-extension decode.
  - Illegal-instruction flagging.
  - Flush.
  - Automatic one-cycle load-use bubble insertion.

Parameters:
- EN_M, 0, 1 = decode RV32M (func7 0000001 on opcode 0110011); 0 = such encodings are illegal.
- EN_LOAD_USE, 1, 1 = insert load-use bubble; 0 = never stall (external forwarding handles it).
- ALU_OP_W, 5, alu_op width; must be at least 5.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instr/pc valid from fetch
- in_ready  out  1  stage accepts instr this cycle
- instr  in  32  instruction word
- pc  in  32  instruction address
- flush  in  1  kill held instruction and any pending bubble
- out_valid  out  1  control word valid to EX
- out_ready  in  1  EX accepts control word
- out_pc  out  32  registered pc
- out_instr  out  32  registered instruction
- alu_op  out  ALU_OP_W  ALU operation
- mask  out  3  load/store size (func3)
- br_type  out  3  branch condition (func3)
- jmp  out  2  0 none, 1 JAL, 2 JALR
- reg_wr, sel_A, sel_B, rd_en, wr_en  out  1 each  as in the core datapath
- wb_sel  out  2  0 ALU, 1 memory, 2 pc+4
- rd, rs1, rs2  out  5 each  register indices
- illegal  out  1  undecodable instruction

Behaviour:
- Reset (synchronous): all outputs, the valid bit and the hazard flag go to 0. in_ready is 0 while reset is high.
- Latency is 1 cycle and throughput is 1 instruction/cycle.
- in_ready = !v_q || (out_ready && !bubble), forced to 0 while flush is high.
- The output register loads on in_valid && in_ready. Otherwise it holds, including while out_valid && !out_ready.
- out_valid = v_q && !bubble. Control outputs are stable while out_valid && !out_ready.
- Decode table (sel_A/sel_B/reg_wr/rd_en/wr_en/wb_sel/mask/br_type):
  - R-type (0110011): reg_wr=1, sel_A=1, sel_B=0, wb_sel=0.
  - I-ALU (0010011): as R-type but sel_B=1.
  - LOAD (0000011): reg_wr=1, sel_A=1, sel_B=1, rd_en=1, wb_sel=1, mask=func3.
  - STORE (0100011): sel_A=1, sel_B=1, rd_en=1, wr_en=1, mask=func3.
  - BRANCH (1100011): sel_B=1, br_type=func3.
  - LUI (0110111): reg_wr=1, sel_A=1, sel_B=1.
  - AUIPC (0010111): reg_wr=1, sel_A=0, sel_B=1.
  - JAL (1101111): reg_wr=1, sel_B=1, wb_sel=2, jmp=1.
  - JALR (1100111, func3=000): reg_wr=1, sel_A=1, sel_B=1, wb_sel=2, jmp=2.
- alu_op encoding:
  - Base: add 0, sll 1, slt 2, sltu 3, xor 4, srl 5, sra 6, or 7, and 8, sub 9.
  - M-extension: mul 10, mulh 11, mulhsu 12, mulhu 13, div 14, divu 15, rem 16, remu 17.
  - func7=0100000 selects sub only for R-type func3=000, and sra/srai for func3=101.
- Illegal decode, any of:
  - unknown opcode;
  - R-type func7 not in {0000000, 0100000 where permitted, 0000001 when EN_M};
  - slli/srli/srai with a bad func7;
  - JALR with func3≠000.
- Illegal handling: illegal=1 and reg_wr=rd_en=wr_en=0, jmp=0. The word still flows with out_valid.
- rs1 is used by R, I-ALU, LOAD, STORE, BRANCH and JALR. rs2 is used by R, STORE and BRANCH.
- Load-use interlock (EN_LOAD_USE=1):
  - Trigger: an output handshake issues a LOAD with rd≠0.
  - hz_rd latches that rd and hz_v is set for exactly the next cycle.
  - In that cycle bubble = hz_v && v_q && (rs1 used and equal to hz_rd, or rs2 used and equal to hz_rd).
  - hz_v clears unconditionally after one cycle, so there is at most one bubble per load.
- Flush:
  - v_q←0 and hz_v←0 next cycle; the input is not accepted in the flush cycle.
  - Flush coincident with out_ready: the handshake still completes, but no hazard is recorded.
- Priority: reset > flush > load/handshake.

Decomposition:
- ctrl_pkg holds:
  - opcode constants;
  - alu_op_e enum (ALU_OP_W bits);
  - wb_sel constants;
  - jmp constants;
  - ctrl_word_t struct (all control fields plus rd/rs1/rs2/illegal/used_rs1/used_rs2).
- Sub-module ctrl_decode: purely combinational, instr to ctrl_word_t, parametrised by EN_M. ctrl_decode_stage owns the register, handshake, hazard and flush logic.

Test Plan:
- Reset held 3 cycles, then released with in_valid=1, instr=add x3,x1,x2 (0x002081B3) → out_valid=1 one cycle later, alu_op=0, reg_wr=1, sel_A=1, sel_B=0, rd=3.
- lw x5,0(x1) (0x0000A283) issued with out_ready=1, followed by add x6,x5,x2 (0x00228333) → exactly one cycle out_valid=0 and in_ready=0, then the add presents; with EN_LOAD_USE=0 no gap.
- lw x0 followed by a dependent add on x0, and lw x5 followed by addi x6,x7,1 → no bubble in either case.
- out_ready=0 for 4 cycles with a valid sub (0x40208133) held → alu_op=9 stable, in_ready=0 throughout, no loss or duplication once ready rises.
- EN_M=1: mul (0x022081B3) → alu_op=10. EN_M=0: the same word → illegal=1, reg_wr=0.
- JALR x1,0(x2) (0x000100E7) → jmp=2, wb_sel=2. A flush asserted while it is held → out_valid=0 next cycle and the pending hazard is cleared.
